// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store initiator for the BRAM controller data port.
// Takes one request at a time, aligns byte/halfword lanes, splits word-crossing
// accesses into two transactions and returns a one-cycle response pulse.
module mem_access_unit #(
  parameter int ADRS_W      = 16,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_width,
  input  logic              req_sign,
  input  logic [31:0]       req_adrs,
  input  logic [31:0]       req_data,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ0 = 2'd1,
    REQ1 = 2'd2,
    DONE = 2'd3
  } state_t;

  // Lane mask for an access of the given width starting at lane 0.
  function automatic logic [3:0] width_mask(input logic [1:0] width);
    logic [3:0] mask;
    case (width)
      2'b00:   mask = 4'b1111;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b0001;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Sign/zero extension of a right-aligned load value.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  width,
                                              input logic        sign);
    logic [31:0] ext;
    case (width)
      2'b01:   ext = {{16{sign & raw[15]}}, raw[15:0]};
      2'b10:   ext = {{24{sign & raw[7]}}, raw[7:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  state_t              state_r;
  logic                req_ready_r;
  logic                resp_valid_r;
  logic                resp_err_r;
  logic [31:0]         resp_data_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADRS_W-1:0]   mem_adrs_r;
  logic [3:0]          mem_be_r;
  logic [31:0]         mem_wdata_r;
  logic                store_r;
  logic [1:0]          width_r;
  logic                sign_r;
  logic [1:0]          off_r;
  logic                cross_r;
  logic [3:0]          be_hi_r;
  logic [31:0]         wdata_hi_r;
  logic [31:0]         load_lo_r;

  logic [1:0]          off_s;
  logic [7:0]          be_wide_s;
  logic [63:0]         wdata_wide_s;
  logic                cross_s;
  logic                reject_s;
  logic [1:0]          hi_shift_s;
  logic [31:0]         first_lanes_s;
  logic [31:0]         raw_s;
  logic [31:0]         load_s;
  logic                unused_adrs_s;

  assign unused_adrs_s = ^req_adrs[31:ADRS_W+2];

  // Request decode (lanes, shifted data, crossing) and load assembly from mem_rdata.
  always_comb begin
    off_s         = req_adrs[1:0];
    be_wide_s     = {4'b0000, width_mask(req_width)} << off_s;
    wdata_wide_s  = {32'h0000_0000, req_data} << {off_s, 3'b000};
    cross_s       = |be_wide_s[7:4];
    reject_s      = (req_width == 2'b11) || (cross_s && (ALLOW_SPLIT == 1'b0));
    // Second word's bytes land above the (4 - off) bytes taken from the first word.
    hi_shift_s    = 2'd0 - off_r;
    first_lanes_s = mem_rdata >> {off_r, 3'b000};
    if (state_r == REQ1) begin
      raw_s = load_lo_r | (mem_rdata << {hi_shift_s, 3'b000});
    end else begin
      raw_s = first_lanes_s;
    end
    if (store_r) begin
      load_s = 32'h0000_0000;
    end else begin
      load_s = extend_load(raw_s, width_r, sign_r);
    end
  end

  // Main FSM: request capture, memory handshake sequencing and registered outputs.
  always_ff @(posedge clk_cpu) begin
    if (!reset) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= 32'h0000_0000;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_adrs_r   <= '0;
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
      store_r      <= 1'b0;
      width_r      <= 2'b00;
      sign_r       <= 1'b0;
      off_r        <= 2'b00;
      cross_r      <= 1'b0;
      be_hi_r      <= 4'b0000;
      wdata_hi_r   <= 32'h0000_0000;
      load_lo_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            store_r     <= req_store;
            width_r     <= req_width;
            sign_r      <= req_sign;
            off_r       <= off_s;
            cross_r     <= cross_s;
            be_hi_r     <= be_wide_s[7:4];
            wdata_hi_r  <= wdata_wide_s[63:32];
            if (reject_s) begin
              state_r      <= DONE;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_data_r  <= 32'h0000_0000;
            end else begin
              state_r     <= REQ0;
              mem_req_r   <= 1'b1;
              mem_we_r    <= req_store;
              mem_adrs_r  <= req_adrs[ADRS_W+1:2];
              mem_be_r    <= be_wide_s[3:0];
              mem_wdata_r <= wdata_wide_s[31:0];
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        REQ0: begin
          if (mem_ack && cross_r) begin
            // Second transaction follows immediately at the next word (wraps).
            state_r     <= REQ1;
            load_lo_r   <= first_lanes_s;
            mem_adrs_r  <= mem_adrs_r + ADRS_W'(1'b1);
            mem_be_r    <= be_hi_r;
            mem_wdata_r <= wdata_hi_r;
          end else if (mem_ack) begin
            state_r      <= DONE;
            resp_valid_r <= 1'b1;
            resp_data_r  <= load_s;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
          end else begin
            state_r <= REQ0;
          end
        end
        REQ1: begin
          if (mem_ack) begin
            state_r      <= DONE;
            resp_valid_r <= 1'b1;
            resp_data_r  <= load_s;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
          end else begin
            state_r <= REQ1;
          end
        end
        DONE: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_data_r  <= 32'h0000_0000;
          req_ready_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_data  = resp_data_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_adrs   = mem_adrs_r;
  assign mem_be     = mem_be_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
CPU-side initiator for the data port of the BRAM memory controller. Accepts one load/store request at a time from the execute stage and drives word-addressed, byte-enabled memory transactions over a req/ack handshake. Handles byte/halfword lane alignment, sign/zero extension, and splitting of accesses that cross a word boundary into two transactions. Returns the load result or store completion to the pipeline as a one-cycle response pulse.

Parameters:
ADRS_W, 16, width of the memory word address (byte address bits [ADRS_W+1:2]).
ALLOW_SPLIT, 1, 1 = split word-crossing accesses into two transactions; 0 = reject them with err.

Ports:
clk_cpu  input  1  CPU clock; all state changes on the rising edge.
reset  input  1  synchronous, active-low reset.
req_valid  input  1  core request valid.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_store  input  1  1 = store, 0 = load.
req_width  input  2  00 word, 01 half, 10 byte, 11 reserved.
req_sign  input  1  sign-extend load result (H/B only).
req_adrs  input  32  byte address.
req_data  input  32  store data, right-aligned.
resp_valid  output  1  one-cycle completion pulse.
resp_data  output  32  extended load result; 0 for stores and errors.
resp_err  output  1  request rejected; valid with resp_valid.
mem_req  output  1  memory transaction request.
mem_we  output  1  1 = write.
mem_adrs  output  ADRS_W  word address.
mem_be  output  4  byte enables; bit n = byte lane n (bits 8n+7:8n).
mem_wdata  output  32  lane-aligned write data.
mem_ack  input  1  transaction complete; sampled only while mem_req = 1.
mem_rdata  input  32  read word; valid in the mem_ack cycle.

Behaviour:
- Reset (reset = 0 at an edge): state IDLE; mem_req, mem_we, mem_be, mem_wdata, mem_adrs, resp_valid, resp_err, resp_data all 0. req_ready = 0 while reset is low. Any in-flight transaction is abandoned and mem_req drops at that edge.
- States: IDLE, REQ0, REQ1, DONE.
- IDLE: req_ready = 1. A request is accepted when req_valid & req_ready at an edge. All fields are captured in that cycle; later input changes are ignored. Let off = adrs[1:0] and n = 4/2/1 bytes for W/H/B. The access crosses a word boundary when off + n > 4.
- Accept with width 11, or a crossing access when ALLOW_SPLIT = 0: go to DONE with err set. No mem_req is issued.
- Otherwise go to REQ0.
- REQ0: mem_req = 1, mem_adrs = adrs[ADRS_W+1:2]. mem_be selects lanes off..min(off+n-1, 3). mem_wdata = low 32 bits of ({32'b0, data} << 8*off). mem_we = store.
  - All mem_* outputs are registered and held stable until mem_ack.
  - On mem_ack: if crossing, go to REQ1, else DONE.
  - Load lanes are captured from mem_rdata in the ack cycle.
- REQ1: mem_adrs = first word address + 1, wrapping modulo 2^ADRS_W. mem_be selects lanes 0..off+n-5. mem_wdata = high 32 bits of the shifted value. On mem_ack go to DONE.
- mem_req deasserts in the cycle after the final ack. There are no idle cycles between REQ0 and REQ1.
- Load assembly: bytes come from the first word at lanes off..3, then the second word at lanes 0.., packed little-endian from bit 0.
  - H: bits 31:16 are copies of bit 15 if sign = 1, else 0.
  - B: bits 31:8 are copies of bit 7 if sign = 1, else 0.
  - W: req_sign is ignored.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE. resp_data is the assembled load value, or 0 for a store or error.
- Latency, zero-wait memory: accept at edge k; mem_req high k+1..k+1 (aligned) or k+1..k+2 (split); resp_valid in the cycle after the last ack. Aligned: accept to resp = 2 cycles. Split: 3 cycles. Each wait cycle adds 1.
- Throughput: at most one outstanding request. req_ready = 0 from accept through DONE.
- mem_ack while mem_req = 0 is ignored.
- Byte accesses never split. A halfword at off 1 stays in one word (be 0110). Only a halfword at off 3 splits.

Test Plan:
1. lw 0x10, mem_rdata 0xDEADBEEF, ack in first req cycle -> one transaction: adrs 0x4, be 1111, we 0; resp_data 0xDEADBEEF 2 cycles after accept.
2. lb signed 0x13, mem_rdata 0x80112233 -> be 1000, resp 0xFFFFFF80. Repeat as lbu -> resp 0x00000080.
3. sh 0x0E, data 0x1234BEEF -> adrs 0x3, be 1100, wdata 0xBEEF0000, we 1; resp_data 0, err 0.
4. sw 0x21, data 0xAABBCCDD -> first transaction: word 0x8, be 1110, wdata 0xBBCCDD00. Second: word 0x9, be 0001, wdata 0x000000AA.
5. lw 0x23, 3 wait cycles per ack, words 0x11223344 then 0x55667788 -> second adrs 0x9, be 0111; resp 0x66778811 in cycle 9 after accept. Also cover split at the top word: ADRS_W = 16, word 0xFFFF wraps to 0x0000.
6. With ALLOW_SPLIT = 0, lh 0x07 -> no mem_req, resp_err = 1 after 1 cycle. Separately, reset low during a REQ0 wait -> mem_req 0 next edge, resp_valid never asserted, req_ready = 1 one cycle after reset releases.
